// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared state/kind encodings and HD44780 command bytes for the
//               LCD character writer.
// Revision    : 1.0
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_INIT = 3'd0,
        ST_IDLE      = 3'd1,
        ST_SETUP     = 3'd2,
        ST_PULSE     = 3'd3,
        ST_WAIT      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        KIND_DATA  = 2'd0,
        KIND_ADDR  = 2'd1,
        KIND_CLEAR = 2'd2
    } kind_t;

    localparam logic [7:0] LCD_CMD_CLEAR  = 8'h01;
    localparam logic [7:0] LCD_ADDR_LINE0 = 8'h80;
    localparam logic [7:0] LCD_ADDR_LINE1 = 8'hC0;

    function automatic int lcd_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_strobe.sv
`default_nettype none
// ============================================================================
// Module      : lcd_strobe
// Description : SETUP / PULSE / WAIT timing for one HD44780 bus write.
// Revision    : 1.0
// ============================================================================
module lcd_strobe
    import lcd_pkg::*;
#(
    parameter int EN_HIGH_CYC  = 12,
    parameter int CMD_WAIT_CYC = 1390,
    parameter int CLR_WAIT_CYC = 45900
) (
    input  logic clk,
    input  logic rst,
    input  logic i_go,
    input  logic i_long_wait,
    output logic o_en,
    output logic o_done
);

    localparam int MAX_WAIT = lcd_max3(EN_HIGH_CYC, CMD_WAIT_CYC, CLR_WAIT_CYC);
    localparam int CNT_W    = $clog2(MAX_WAIT) + 1;

    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_pulse_ld = CNT_W'(EN_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] c_cmd_ld   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] c_clr_ld   = CNT_W'(CLR_WAIT_CYC - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_ld_val;
    logic             w_cnt_ld;
    logic             w_cnt_zero;
    logic             w_done;
    logic             r_en;

    assign w_cnt_zero = (r_cnt == '0);

    // Each state reloads the down-counter with (duration - 1) on entry;
    // SETUP loads zero so it lasts exactly one cycle.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_ld     = 1'b0;
        w_cnt_ld_val = '0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_go) begin
                    w_state_nx = ST_SETUP;
                    w_cnt_ld   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (w_cnt_zero) begin
                    w_state_nx   = ST_PULSE;
                    w_cnt_ld     = 1'b1;
                    w_cnt_ld_val = c_pulse_ld;
                end
            end
            ST_PULSE: begin
                if (w_cnt_zero) begin
                    w_state_nx   = ST_WAIT;
                    w_cnt_ld     = 1'b1;
                    w_cnt_ld_val = i_long_wait ? c_clr_ld : c_cmd_ld;
                end
            end
            ST_WAIT: begin
                if (w_cnt_zero) begin
                    w_done = 1'b1;
                    if (i_go) begin
                        w_state_nx = ST_SETUP;
                        w_cnt_ld   = 1'b1;
                    end else begin
                        w_state_nx = ST_IDLE;
                    end
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_en    <= (w_state_nx == ST_PULSE);
            if (w_cnt_ld) begin
                r_cnt <= w_cnt_ld_val;
            end else if (!w_cnt_zero) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
        end
    end

    assign o_en   = r_en;
    assign o_done = w_done;

endmodule
`default_nettype wire

// File: rtl/lcd_char_writer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_char_writer
// Description : Writes handshaked ASCII bytes to a 2-line HD44780, wrapping
//               the cursor between lines and servicing clear requests.
// Revision    : 1.0
// ============================================================================
module lcd_char_writer
    import lcd_pkg::*;
#(
    parameter int EN_HIGH_CYC  = 12,
    parameter int CMD_WAIT_CYC = 1390,
    parameter int CLR_WAIT_CYC = 45900,
    parameter int COLS         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic       clear_req,
    output logic       busy,
    output logic       lcd_en,
    output logic       lcd_rs,
    output logic [7:0] lcd_db
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    localparam logic [COL_W-1:0] c_col_last = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0] c_col_one  = COL_W'(1);

    // ST_SETUP here covers the whole write sequence run by lcd_strobe,
    // including a chained line-end address write.
    state_t           r_state;
    state_t           w_state_nx;
    kind_t            r_kind;
    kind_t            w_kind_nx;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col_nx;
    logic             r_line;
    logic             w_line_nx;
    logic             r_rs;
    logic             w_rs_nx;
    logic [7:0]       r_db;
    logic [7:0]       w_db_nx;
    logic             w_go;
    logic             w_char_ready;
    logic             w_strobe_en;
    logic             w_strobe_done;

    lcd_strobe #(
        .EN_HIGH_CYC  (EN_HIGH_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC)
    ) u_strobe (
        .clk         (clk),
        .rst         (rst),
        .i_go        (w_go),
        .i_long_wait (r_kind == KIND_CLEAR),
        .o_en        (w_strobe_en),
        .o_done      (w_strobe_done)
    );

    always_comb begin
        w_state_nx   = r_state;
        w_kind_nx    = r_kind;
        w_col_nx     = r_col;
        w_line_nx    = r_line;
        w_rs_nx      = r_rs;
        w_db_nx      = r_db;
        w_go         = 1'b0;
        w_char_ready = 1'b0;
        case (r_state)
            ST_WAIT_INIT: begin
                if (init_done) begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_IDLE: begin
                w_char_ready = ~clear_req;
                if (clear_req) begin
                    w_kind_nx  = KIND_CLEAR;
                    w_rs_nx    = 1'b0;
                    w_db_nx    = LCD_CMD_CLEAR;
                    w_go       = 1'b1;
                    w_state_nx = ST_SETUP;
                end else if (char_valid) begin
                    w_kind_nx  = KIND_DATA;
                    w_rs_nx    = 1'b1;
                    w_db_nx    = char_data;
                    w_go       = 1'b1;
                    w_state_nx = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (w_strobe_done) begin
                    case (r_kind)
                        KIND_DATA: begin
                            if (r_col == c_col_last) begin
                                w_col_nx  = '0;
                                w_line_nx = ~r_line;
                                w_kind_nx = KIND_ADDR;
                                w_rs_nx   = 1'b0;
                                w_db_nx   = r_line ? LCD_ADDR_LINE0 : LCD_ADDR_LINE1;
                                w_go      = 1'b1;
                            end else begin
                                w_col_nx   = r_col + c_col_one;
                                w_state_nx = ST_IDLE;
                            end
                        end
                        KIND_CLEAR: begin
                            w_col_nx   = '0;
                            w_line_nx  = 1'b0;
                            w_state_nx = ST_IDLE;
                        end
                        default: w_state_nx = ST_IDLE;
                    endcase
                end
            end
            default: w_state_nx = ST_WAIT_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_WAIT_INIT;
            r_kind  <= KIND_DATA;
            r_col   <= '0;
            r_line  <= 1'b0;
            r_rs    <= 1'b0;
            r_db    <= 8'h00;
        end else begin
            r_state <= w_state_nx;
            r_kind  <= w_kind_nx;
            r_col   <= w_col_nx;
            r_line  <= w_line_nx;
            r_rs    <= w_rs_nx;
            r_db    <= w_db_nx;
        end
    end

    assign char_ready = w_char_ready;
    assign busy       = (r_state != ST_IDLE);
    assign lcd_en     = w_strobe_en;
    assign lcd_rs     = r_rs;
    assign lcd_db     = r_db;

endmodule
`default_nettype wire

// File: tb/tb_lcd_char_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_char_writer
// Description : Scoreboard bench for lcd_char_writer with a cursor-level model.
// Revision    : 1.0
// ============================================================================
module tb_lcd_char_writer;

    localparam int EN_HIGH_CYC  = 2;
    localparam int CMD_WAIT_CYC = 5;
    localparam int CLR_WAIT_CYC = 20;
    localparam int COLS         = 4;
    localparam int T_WR         = 1 + EN_HIGH_CYC + CMD_WAIT_CYC;
    localparam int T_CLR        = 1 + EN_HIGH_CYC + CLR_WAIT_CYC;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       init_done  = 1'b0;
    logic       char_valid = 1'b0;
    logic [7:0] char_data  = 8'h00;
    logic       clear_req  = 1'b0;
    logic       char_ready;
    logic       busy;
    logic       lcd_en;
    logic       lcd_rs;
    logic [7:0] lcd_db;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [8:0] exp_q[$];
    int         m_col  = 0;
    int         m_line = 0;

    always #5 clk = ~clk;

    lcd_char_writer #(
        .EN_HIGH_CYC  (EN_HIGH_CYC),
        .CMD_WAIT_CYC (CMD_WAIT_CYC),
        .CLR_WAIT_CYC (CLR_WAIT_CYC),
        .COLS         (COLS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .busy       (busy),
        .lcd_en     (lcd_en),
        .lcd_rs     (lcd_rs),
        .lcd_db     (lcd_db)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out, got no event expected one", name);
    endtask

    // Cursor model: a byte lands at the current column; filling a line moves
    // to the other line and costs one extra address write.
    task automatic model_char(input logic [7:0] d, output int busy_cyc);
        exp_q.push_back({1'b1, d});
        busy_cyc = T_WR;
        m_col++;
        if (m_col == COLS) begin
            m_col  = 0;
            m_line = 1 - m_line;
            exp_q.push_back({1'b0, (m_line == 1) ? 8'hC0 : 8'h80});
            busy_cyc = 2 * T_WR;
        end
    endtask

    // Monitor: one scoreboard pop per EN rising edge, plus strobe-shape checks.
    initial begin
        logic       prev_en;
        logic [8:0] prev_bus;
        logic [8:0] wr_bus;
        int         hi;
        prev_en  = 1'b0;
        prev_bus = '0;
        wr_bus   = '0;
        hi       = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_en = 1'b0;
                hi      = 0;
            end else begin
                if (lcd_en && !prev_en) begin
                    check("setup_bus", {lcd_rs, lcd_db}, prev_bus);
                    wr_bus = {lcd_rs, lcd_db};
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL sb_unexpected: got write 0x%0h expected none", wr_bus);
                    end else begin
                        check("sb_write", wr_bus, exp_q.pop_front());
                    end
                    hi = 1;
                end else if (lcd_en) begin
                    hi++;
                end else if (prev_en) begin
                    check("en_width", hi, EN_HIGH_CYC);
                    check("hold_bus", {lcd_rs, lcd_db}, wr_bus);
                    hi = 0;
                end
                prev_en = lcd_en;
            end
            prev_bus = {lcd_rs, lcd_db};
        end
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (char_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("wait_ready");
    endtask

    task automatic measure_low(input string name, input int exp_cyc);
        int  low;
        bit  seen;
        low  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (char_ready) begin
                seen = 1'b1;
                break;
            end
            low++;
        end
        if (!seen) fail_now(name);
        else check(name, low, exp_cyc);
    endtask

    task automatic send(input logic [7:0] d, input bit measure, input bit jitter);
        bit         got;
        logic [7:0] acc;
        int         exp_cyc;
        @(posedge clk); #1;
        char_valid = 1'b1;
        char_data  = d;
        got        = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (char_ready) begin
                got = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (jitter) char_data = 8'($urandom);
        end
        if (!got) begin
            char_valid = 1'b0;
            fail_now("send_accept");
            return;
        end
        @(posedge clk);
        acc = char_data;
        #1;
        char_valid = 1'b0;
        model_char(acc, exp_cyc);
        check("acc_rs", lcd_rs, 1);
        check("acc_db", lcd_db, acc);
        check("acc_en", lcd_en, 0);
        check("acc_busy", busy, 1);
        if (measure) measure_low("ready_low", exp_cyc);
    endtask

    task automatic do_clear(input bit with_char, input logic [7:0] d);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        @(posedge clk); #1;
        clear_req = 1'b1;
        if (with_char) begin
            char_valid = 1'b1;
            char_data  = d;
        end
        @(negedge clk);
        check("clr_ready", char_ready, 0);
        @(posedge clk); #1;
        clear_req  = 1'b0;
        char_valid = 1'b0;
        exp_q.push_back({1'b0, 8'h01});
        m_col  = 0;
        m_line = 0;
        check("clr_rs", lcd_rs, 0);
        check("clr_db", lcd_db, 8'h01);
        check("clr_busy", busy, 1);
        measure_low("clr_low", T_CLR);
    endtask

    task automatic bring_up(input int idle_cycles);
        for (int i = 0; i < idle_cycles; i++) begin
            @(negedge clk);
            check("init_ready", char_ready, 0);
            check("init_en", lcd_en, 0);
            check("init_db", lcd_db, 8'h00);
        end
        @(posedge clk); #1;
        init_done = 1'b1;
        @(posedge clk); #1;
        check("init_ready_up", char_ready, 1);
        init_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_en", lcd_en, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_db", lcd_db, 8'h00);
        check("rst_ready", char_ready, 0);
        check("rst_busy", busy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        bring_up(10);

        send(8'h41, 1'b1, 1'b0);
        do_clear(1'b1, 8'h5A);
        for (int k = 0; k < 4; k++) send(8'(8'h30 + k), 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) send(8'(8'h50 + k), 1'b1, 1'b0);

        send(8'h61, 1'b0, 1'b0);
        send(8'h62, 1'b1, 1'b1);

        send(8'h63, 1'b0, 1'b0);
        @(posedge clk); #1;
        clear_req = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        wait_ready(ok);

        repeat (40) begin
            if ($urandom_range(0, 7) == 0) do_clear(1'b0, 8'h00);
            else send(8'($urandom), 1'b1, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        wait_ready(ok);
        send(8'h77, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (lcd_en) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) fail_now("pulse_seen");
        #1;
        rst = 1'b1;
        #1;
        check("arst_en", lcd_en, 0);
        check("arst_rs", lcd_rs, 0);
        check("arst_db", lcd_db, 8'h00);
        check("arst_ready", char_ready, 0);
        check("arst_busy", busy, 1);
        m_col  = 0;
        m_line = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bring_up(5);
        for (int k = 0; k < 6; k++) send(8'($urandom), 1'b1, 1'b0);

        repeat (5) @(posedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
